mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle signed multiply/divide unit fed by the control unit's DIVMULT_Control select.
//  Control unit issues a one-cycle start with op, rs and rt values; unit iterates WIDTH cycles.
//  Result lands in internal HI/LO registers, read back through MemToReg (mfhi/mflo).
//  Raises div_zero so the control unit can take the divide-by-zero exception path.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk       in   1      system clock, all state on rising edge
//  reset_in  in   1      synchronous reset, active-low
//  start     in   1      one-cycle request; sampled only in IDLE
//  op        in   1      1 = mult, 0 = div (same encoding as DIVMULT_Control)
//  a         in   WIDTH  rs value: multiplicand / dividend, two's complement
//  b         in   WIDTH  rt value: multiplier / divisor, two's complement
//  busy      out  1      high from the cycle after start accept until done
//  done      out  1      one-cycle pulse; HI/LO (or div_zero) valid in this cycle
//  div_zero  out  1      one-cycle pulse with done when div had b == 0
//  hi        out  WIDTH  HI register: mult upper half / div remainder
//  lo        out  WIDTH  LO register: mult lower half / div quotient
// BEHAVIOUR
//  Reset (reset_in==0 at clk edge): state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0,
//   counter=0. This takes priority over everything, including an in-flight operation,
//   which is abandoned with no done pulse.
//  FSM states: IDLE, MULT, DIV, FINISH.
//   IDLE  : start&op -> latch a,b; clear accumulator; -> MULT.
//           start&!op&b!=0 -> latch |a|,|b| and sign flags; -> DIV.
//           start&!op&b==0 -> -> FINISH with dz flag set; hi/lo left unchanged.
//   MULT  : radix-2 Booth step per cycle on {acc,Q,q-1}, 2*WIDTH+1 bits, arithmetic shift.
//           After WIDTH steps -> FINISH.
//   DIV   : restoring step per cycle on unsigned magnitudes. After WIDTH steps -> FINISH.
//   FINISH: write hi/lo (skipped when dz); done=1; div_zero=dz; -> IDLE.
//  Latency: start accepted at edge N; done high during cycle N+WIDTH+1 (33 for WIDTH=32).
//   Divide by zero: done=div_zero=1 during cycle N+1.
//  busy: 1 in MULT/DIV/FINISH and 0 in IDLE. A start while busy is ignored: no queueing,
//   operands not re-latched. The next start is accepted in the cycle after done.
//  Mult: full signed 2*WIDTH product; {hi,lo} = a*b. No overflow flag.
//  Div: quotient truncates toward zero. Remainder takes the sign of the dividend.
//   Both corrections are applied in FINISH from the latched sign flags.
//   -2^31 / -1: lo=0x80000000, hi=0 (wrap, no trap).
//  hi/lo hold their value between operations and are only updated in FINISH.
//  Outputs are registered; a, b and op may change freely after the start cycle.
// STRUCTURE
//  Shared package: MDU_OP_MULT=1'b1, MDU_OP_DIV=1'b0, and state encoding localparams.
//   DIVMULT_Control in the control unit uses the same op constants.
//  Natural sub-module: mdu_iter_step, a combinational Booth/restoring single-step datapath
//   selected by op. The FSM, counter and HI/LO registers stay in mult_div_unit.
// TESTING
//  Reset: hold reset_in=0 for 2 cycles -> hi=lo=0, busy=done=div_zero=0.
//  Mult: a=7, b=-3, start op=1 -> done at +33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  Mult extreme: a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
//  Div: a=-7, b=2, op=0 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//   Then a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
//  Div by zero: preload hi/lo via mult 5*6, then div a=9, b=0 ->
//   done=div_zero=1 at +1, hi=0, lo=30 unchanged.
//  Start while busy and reset mid-op:
//   start again at +10 of a mult -> ignored, original result at +33.
//   reset_in=0 at +15 of a div -> IDLE, no done, hi=lo=0.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit.
//   MDU_OP_MULT / MDU_OP_DIV : op encoding, identical to DIVMULT_Control in the control unit
//   MDU_ST_*                 : FSM state encodings
//   mdu_state_e              : FSM state type built on those encodings
package mult_div_unit_pkg;

    localparam logic MDU_OP_MULT = 1'b1;
    localparam logic MDU_OP_DIV  = 1'b0;

    localparam logic [1:0] MDU_ST_IDLE   = 2'd0;
    localparam logic [1:0] MDU_ST_MULT   = 2'd1;
    localparam logic [1:0] MDU_ST_DIV    = 2'd2;
    localparam logic [1:0] MDU_ST_FINISH = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = MDU_ST_IDLE,
        ST_MULT   = MDU_ST_MULT,
        ST_DIV    = MDU_ST_DIV,
        ST_FINISH = MDU_ST_FINISH
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_iter_step.sv
// Combinational single-iteration datapath for the multiply/divide unit.
//   op_s       in   1      MDU_OP_MULT: radix-2 Booth step, MDU_OP_DIV: restoring step
//   acc_s      in   WIDTH  Booth accumulator / partial remainder
//   q_s        in   WIDTH  Booth multiplier shift reg / dividend-quotient shift reg
//   q_m1_s     in   1      Booth q(-1) bit (unused for divide)
//   m_s        in   WIDTH  multiplicand (signed) / divisor magnitude (unsigned)
//   acc_nxt_s  out  WIDTH  accumulator after this step
//   q_nxt_s    out  WIDTH  Q register after this step
//   q_m1_nxt_s out  1      q(-1) after this step
module mdu_iter_step
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op_s,
    input  logic [WIDTH-1:0] acc_s,
    input  logic [WIDTH-1:0] q_s,
    input  logic             q_m1_s,
    input  logic [WIDTH-1:0] m_s,
    output logic [WIDTH-1:0] acc_nxt_s,
    output logic [WIDTH-1:0] q_nxt_s,
    output logic             q_m1_nxt_s
);

    // One extra bit on the Booth adder: acc - m overflows WIDTH bits when
    // m is the most negative value; the shifted result always fits again.
    logic [WIDTH:0] booth_sum_s;
    // Trial subtraction for the restoring step; MSB is the borrow.
    logic [WIDTH:0] trial_s;

    // Single Booth or restoring iteration selected by op
    always_comb begin
        acc_nxt_s   = acc_s;
        q_nxt_s     = q_s;
        q_m1_nxt_s  = q_m1_s;
        booth_sum_s = {(WIDTH+1){1'b0}};
        trial_s     = {(WIDTH+1){1'b0}};
        if (op_s == MDU_OP_MULT) begin
            case ({q_s[0], q_m1_s})
                2'b01:   booth_sum_s = {acc_s[WIDTH-1], acc_s} + {m_s[WIDTH-1], m_s};
                2'b10:   booth_sum_s = {acc_s[WIDTH-1], acc_s} - {m_s[WIDTH-1], m_s};
                default: booth_sum_s = {acc_s[WIDTH-1], acc_s};
            endcase
            // Arithmetic shift right of {acc, Q, q-1}
            acc_nxt_s  = booth_sum_s[WIDTH:1];
            q_nxt_s    = {booth_sum_s[0], q_s[WIDTH-1:1]};
            q_m1_nxt_s = q_s[0];
        end else begin
            // Shift next dividend bit into the remainder, try subtracting the divisor
            trial_s = {acc_s, q_s[WIDTH-1]} - {1'b0, m_s};
            if (trial_s[WIDTH]) begin
                acc_nxt_s = {acc_s[WIDTH-2:0], q_s[WIDTH-1]};
                q_nxt_s   = {q_s[WIDTH-2:0], 1'b0};
            end else begin
                acc_nxt_s = trial_s[WIDTH-1:0];
                q_nxt_s   = {q_s[WIDTH-2:0], 1'b1};
            end
            q_m1_nxt_s = 1'b0;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply/divide unit with HI/LO result registers.
// A one-cycle start in IDLE launches WIDTH Booth (mult) or restoring (div)
// iterations; FINISH writes HI/LO with sign correction and pulses done.
//   clk       in   1      system clock
//   reset_in  in   1      synchronous reset, active-low
//   start     in   1      one-cycle request, sampled only in IDLE
//   op        in   1      1 = mult, 0 = div
//   a         in   WIDTH  multiplicand / dividend (two's complement)
//   b         in   WIDTH  multiplier / divisor (two's complement)
//   busy      out  1      operation in progress
//   done      out  1      one-cycle pulse, HI/LO valid
//   div_zero  out  1      pulse with done when a divide had b == 0
//   hi        out  WIDTH  product upper half / remainder
//   lo        out  WIDTH  product lower half / quotient
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

    mdu_state_e       state_r;
    mdu_state_e       state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] m_r;
    logic             q_m1_r;
    logic             op_r;
    logic             dz_r;
    logic             neg_quo_r;
    logic             neg_rem_r;
    logic             busy_r;
    logic             done_r;
    logic             div_zero_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH-1:0] acc_step_s;
    logic [WIDTH-1:0] q_step_s;
    logic             q_m1_step_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic             b_zero_s;

    assign a_mag_s  = a[WIDTH-1] ? (~a + ONE_W) : a;
    assign b_mag_s  = b[WIDTH-1] ? (~b + ONE_W) : b;
    assign b_zero_s = (b == ZERO_W);

    mdu_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op_s       (op_r),
        .acc_s      (acc_r),
        .q_s        (q_r),
        .q_m1_s     (q_m1_r),
        .m_s        (m_r),
        .acc_nxt_s  (acc_step_s),
        .q_nxt_s    (q_step_s),
        .q_m1_nxt_s (q_m1_step_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (op == MDU_OP_MULT) begin
                        state_nxt_s = ST_MULT;
                    end else if (b_zero_s) begin
                        state_nxt_s = ST_FINISH;
                    end else begin
                        state_nxt_s = ST_DIV;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MULT, ST_DIV: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_FINISH: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand latch, iteration counter and shared Booth/restoring working registers
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            cnt_r     <= {CW{1'b0}};
            acc_r     <= ZERO_W;
            q_r       <= ZERO_W;
            m_r       <= ZERO_W;
            q_m1_r    <= 1'b0;
            op_r      <= MDU_OP_DIV;
            dz_r      <= 1'b0;
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cnt_r  <= {CW{1'b0}};
                        acc_r  <= ZERO_W;
                        q_m1_r <= 1'b0;
                        op_r   <= op;
                        if (op == MDU_OP_MULT) begin
                            q_r       <= b;
                            m_r       <= a;
                            dz_r      <= 1'b0;
                            neg_quo_r <= 1'b0;
                            neg_rem_r <= 1'b0;
                        end else begin
                            // Divide on magnitudes; signs restored in FINISH
                            q_r       <= a_mag_s;
                            m_r       <= b_mag_s;
                            dz_r      <= b_zero_s;
                            neg_quo_r <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_rem_r <= a[WIDTH-1];
                        end
                    end
                end
                ST_MULT, ST_DIV: begin
                    acc_r  <= acc_step_s;
                    q_r    <= q_step_s;
                    q_m1_r <= q_m1_step_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered status outputs and HI/LO write-back
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= ZERO_W;
            lo_r       <= ZERO_W;
        end else begin
            busy_r     <= (state_nxt_s != ST_IDLE);
            done_r     <= (state_r == ST_FINISH);
            div_zero_r <= (state_r == ST_FINISH) && dz_r;
            if ((state_r == ST_FINISH) && !dz_r) begin
                if (op_r == MDU_OP_MULT) begin
                    hi_r <= acc_r;
                    lo_r <= q_r;
                end else begin
                    // Remainder follows dividend sign, quotient truncates toward zero
                    hi_r <= neg_rem_r ? (~acc_r + ONE_W) : acc_r;
                    lo_r <= neg_quo_r ? (~q_r + ONE_W) : q_r;
                end
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    logic        clk;
    logic        reset_in;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    // Reference HI/LO contents
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Issue one operation; optionally poke a second start 'poke' cycles after accept.
    task automatic run_op(input string tag, input logic o, input logic [31:0] x,
                          input logic [31:0] y, input int poke);
        int     lat;
        int     exp_lat;
        logic   exp_dz;
        longint sx;
        longint sy;
        longint prod;
        longint qq;
        longint rr;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        exp_dz = 1'b0;
        if (o) begin
            prod = sx * sy;
            exp_hi = prod[63:32];
            exp_lo = prod[31:0];
            exp_lat = 33;
        end else if (y == 32'h0) begin
            exp_dz = 1'b1;
            exp_lat = 1;
        end else begin
            qq = sx / sy;
            rr = sx % sy;
            exp_hi = rr[31:0];
            exp_lo = qq[31:0];
            exp_lat = 33;
        end
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
        check({tag, "_busy"}, {63'h0, busy}, 64'h1);
        lat = 0;
        while (lat < 100) begin
            if (poke != 0 && lat == poke) begin
                start = 1'b1; op = ~o; a = $urandom; b = 32'h0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_hi"}, {32'h0, hi}, {32'h0, exp_hi});
        check({tag, "_lo"}, {32'h0, lo}, {32'h0, exp_lo});
        check({tag, "_divzero"}, {63'h0, div_zero}, {63'h0, exp_dz});
        check({tag, "_busy_done"}, {63'h0, busy}, 64'h0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {63'h0, done}, 64'h0);
    endtask

    initial begin
        int seen;
        logic [31:0] rx;
        logic [31:0] ry;
        start = 1'b0; op = 1'b0; a = 32'h0; b = 32'h0;
        reset_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", {32'h0, hi}, 64'h0);
        check("rst_lo", {32'h0, lo}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_dz", {63'h0, div_zero}, 64'h0);
        @(negedge clk);
        reset_in = 1'b1;

        run_op("mult_7_m3", 1'b1, 32'd7, 32'hFFFF_FFFD, 0);
        check("mult_7_m3_hi_const", {32'h0, hi}, 64'hFFFF_FFFF);
        check("mult_7_m3_lo_const", {32'h0, lo}, 64'hFFFF_FFEB);
        run_op("mult_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
        check("mult_min_hi_const", {32'h0, hi}, 64'h4000_0000);
        run_op("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_m7_2_lo_const", {32'h0, lo}, 64'hFFFF_FFFD);
        run_op("div_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_min_m1_lo_const", {32'h0, lo}, 64'h8000_0000);
        run_op("mult_5_6", 1'b1, 32'd5, 32'd6, 0);
        run_op("div_9_0", 1'b0, 32'd9, 32'd0, 0);
        check("div_9_0_lo_const", {32'h0, lo}, 64'd30);
        run_op("busy_poke", 1'b1, 32'd7, 32'hFFFF_FFFD, 10);

        for (int i = 0; i < 6; i++) begin
            rx = $urandom; ry = $urandom;
            run_op("rand_mult", 1'b1, rx, ry, 0);
            rx = $urandom; ry = $urandom;
            if (i == 2) ry = 32'd1;
            if (i == 3) ry = $urandom_range(1, 9);
            if (ry == 32'h0) ry = 32'd3;
            run_op("rand_div", 1'b0, rx, ry, 0);
        end
        run_op("rand_dz", 1'b0, $urandom, 32'h0, 0);

        // Reset in the middle of a divide abandons it
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'hFFFF_FF9C; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset_in = 1'b0;
        @(posedge clk);
        #1;
        reset_in = 1'b1;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        check("midrst_busy", {63'h0, busy}, 64'h0);
        check("midrst_hi", {32'h0, hi}, {32'h0, exp_hi});
        check("midrst_lo", {32'h0, lo}, {32'h0, exp_lo});
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        check("midrst_no_done", 64'(seen), 64'h0);
        run_op("post_rst_mult", 1'b1, 32'hFFFF_FF9C, 32'd7, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
